hs_tx_arbiter: RTL and testbench
================================

HS_TX_ARBITER -- requirements
Module: hs_tx_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the payload width.
REQ-002 The module SHALL have parameter NUM_REQ, default 4, giving the requester count (range 2..8).
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 1023, giving the ack-wait limit in iTxClk cycles.
REQ-004 iTxClk  input  1  single clock; all logic on its rising edge.
REQ-005 iRstnTx  input  1  reset; asynchronous assert, active-low.
REQ-006 iReq  input  NUM_REQ  per-requester request level, held until the matching oDone bit.
REQ-007 iReqData  input  NUM_REQ*DATA_WIDTH  payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 oDone  output  NUM_REQ  one-cycle pulse to the served requester at transfer end.
REQ-009 oBusy  output  1  high whenever state is not IDLE.
REQ-010 oTxRdy  output  1  four-phase channel request to the receiving clock domain.
REQ-011 oData  output  DATA_WIDTH  channel payload, registered.
REQ-012 iRxAck  input  1  channel acknowledge, asynchronous to iTxClk.
REQ-013 oTimeout  output  1  one-cycle pulse on aborted transfer (driven 0 when HS_ARB_TIMEOUT_EN is undefined).

Function
REQ-014 iRxAck SHALL pass through a two-flop synchronizer; all FSM decisions SHALL use only the synchronized value (rAckSync).
REQ-015 The FSM SHALL have the states IDLE, ASSERT_RDY and WAIT_ACK_LOW.
REQ-016 In IDLE with any iReq bit set, the FSM SHALL grant one requester, register its payload into oData, set oTxRdy=1 on the next edge, and enter ASSERT_RDY.
REQ-017 Grant selection SHALL be round-robin: search starts at index rPtr and wraps modulo NUM_REQ; after a grant to index g, rPtr becomes (g+1) mod NUM_REQ.
REQ-018 In ASSERT_RDY with rAckSync=1, the FSM SHALL set oTxRdy=0 and enter WAIT_ACK_LOW.
REQ-019 In WAIT_ACK_LOW with rAckSync=0, the FSM SHALL pulse oDone[g] for exactly one cycle and enter IDLE.
REQ-020 oData SHALL stay constant from the grant edge until the return to IDLE, independent of iReqData changes.
REQ-021 The FSM SHALL not grant in the cycle oDone pulses; the earliest next oTxRdy rise SHALL be 2 cycles after the oDone edge.
REQ-022 An iReq bit that drops before its grant SHALL be ignored; a drop after its grant SHALL not abort the transfer.
REQ-023 Simultaneous requests SHALL be served one per handshake in round-robin order, and no requester SHALL wait more than NUM_REQ-1 transfers.
REQ-024 A rAckSync=1 seen in IDLE (stale ack) SHALL block new grants until it returns to 0.

Reset
REQ-025 Reset SHALL set state=IDLE, rPtr=0, oTxRdy=0, oData=0, oDone=0, oBusy=0, oTimeout=0, both synchronizer flops=0, and the timeout counter=0.
REQ-026 A reset asserted mid-transfer SHALL take effect immediately (asynchronously), and after release the FSM SHALL obey REQ-024 before its first grant.

Configuration
REQ-027 With macro HS_ARB_TIMEOUT_EN defined, a counter SHALL count cycles in ASSERT_RDY; reaching TIMEOUT_CYCLES SHALL set oTxRdy=0, pulse oTimeout and oDone[g] together for one cycle, and enter WAIT_ACK_LOW without a second oDone.
REQ-028 With HS_ARB_TIMEOUT_EN undefined, there SHALL be no counter, oTimeout SHALL be tied to 0, and ASSERT_RDY SHALL wait indefinitely.

Structure
REQ-029 A shared package hs_pkg SHALL hold the FSM state enum (IDLE=0, ASSERT_RDY=1, WAIT_ACK_LOW=2) and the constant SYNC_STAGES=2.
REQ-030 The synchronizer SHALL be the sub-module hs_sync (parameterized width, flop chain), reused by other handshake blocks.

Verification
REQ-031 Single request: iReq=4'b0100 with payload 0xDEADBEEF, and the receiver acks 3 cycles after oTxRdy -> oData=0xDEADBEEF, oDone=4'b0100 for 1 cycle, rPtr=3.
REQ-032 All requesting: iReq=4'b1111 from reset -> oDone order 0,1,2,3,0, each transfer with its own payload.
REQ-033 Wrap-around: rPtr=3 with iReq=4'b1001 -> requester 3 is served first, then requester 0.
REQ-034 Payload change: iReqData[g] changes while oTxRdy=1 -> oData is unchanged until oDone.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES=15): iRxAck held at 0 -> oTxRdy falls 15 cycles into ASSERT_RDY, and oTimeout and oDone pulse together.
REQ-036 Reset: iRstnTx=0 while in WAIT_ACK_LOW with iRxAck=1 -> all outputs are 0 at once, and there is no grant until iRxAck=0 plus 2 cycles.

Source files
------------

// File: rtl/hs_pkg.sv
// hs_pkg: shared definitions for the four-phase handshake blocks.
//   hsState_e   - transmit FSM state encoding
//   SYNC_STAGES - flop count of the acknowledge synchronizer
package hs_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        ASSERT_RDY   = 2'd1,
        WAIT_ACK_LOW = 2'd2
    } hsState_e;

endpackage

// File: rtl/hs_sync.sv
// hs_sync: multi-flop synchronizer chain, reset to zero.
//   iClk  - destination clock
//   iRstn - asynchronous active-low reset
//   iD    - asynchronous input bits
//   oQ    - synchronized output (STAGES flops later)
module hs_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             iClk,
    input  logic             iRstn,
    input  logic [WIDTH-1:0] iD,
    output logic [WIDTH-1:0] oQ
);

    logic [WIDTH-1:0] rChain [STAGES];

    // Shift chain: stage 0 samples the asynchronous input.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                rChain[i] <= '0;
            end
        end else begin
            rChain[0] <= iD;
            for (int unsigned i = 1; i < STAGES; i++) begin
                rChain[i] <= rChain[i-1];
            end
        end
    end

    assign oQ = rChain[STAGES-1];

endmodule

// File: rtl/hs_tx_arbiter.sv
// hs_tx_arbiter: round-robin arbiter feeding one four-phase handshake channel.
// Optional feature macro: HS_ARB_TIMEOUT_EN (abort a transfer whose ack never
// arrives after TIMEOUT_CYCLES cycles in ASSERT_RDY).
//   iTxClk    - clock
//   iRstnTx   - asynchronous active-low reset
//   iReq      - per-requester request level, held until its oDone bit
//   iReqData  - packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   oDone     - one-cycle pulse to the served requester
//   oBusy     - high whenever the FSM is not IDLE
//   oTxRdy    - channel request towards the receiving domain
//   oData     - channel payload, held for the whole transfer
//   iRxAck    - channel acknowledge, asynchronous to iTxClk
//   oTimeout  - one-cycle pulse on an aborted transfer
module hs_tx_arbiter
    import hs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                          iTxClk,
    input  logic                          iRstnTx,
    input  logic [NUM_REQ-1:0]            iReq,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] iReqData,
    output logic [NUM_REQ-1:0]            oDone,
    output logic                          oBusy,
    output logic                          oTxRdy,
    output logic [DATA_WIDTH-1:0]         oData,
    input  logic                          iRxAck,
    output logic                          oTimeout
);

    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 1);

    hsState_e              state;
    hsState_e              nextState;
    logic                  rAckSync;
    logic [PTR_W-1:0]      rPtr;
    logic [PTR_W-1:0]      rGrant;
    logic [PTR_W-1:0]      candIdx;
    logic [PTR_W-1:0]      grantIdx;
    logic                  grantFound;
    logic                  grantValid;
    logic [WARM_W-1:0]     rWarm;
    logic                  syncReady;
    logic                  timeoutHit;
    logic                  abortedQ;

    logic                  nxtTxRdy;
    logic [DATA_WIDTH-1:0] nxtData;
    logic [NUM_REQ-1:0]    nxtDone;
    logic                  nxtTimeout;
    logic [PTR_W-1:0]      nxtPtr;
    logic [PTR_W-1:0]      nxtGrant;

    hs_sync #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) uAckSync (
        .iClk  (iTxClk),
        .iRstn (iRstnTx),
        .iD    (iRxAck),
        .oQ    (rAckSync)
    );

    // The synchronizer reads 0 right after reset regardless of iRxAck, so
    // grants wait until the chain has refilled with a real sample.
    always_ff @(posedge iTxClk or negedge iRstnTx) begin
        if (!iRstnTx) begin
            rWarm <= '0;
        end else if (!syncReady) begin
            rWarm <= rWarm + WARM_W'(1);
        end
    end

    assign syncReady = (rWarm == WARM_W'(SYNC_STAGES));

    // Round-robin search starting at rPtr.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        candIdx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            candIdx = PTR_W'((32'(rPtr) + i) % NUM_REQ);
            if (!grantFound && iReq[candIdx]) begin
                grantFound = 1'b1;
                grantIdx   = candIdx;
            end
        end
    end

    // No grant while a stale ack is visible or while oDone is still pulsing.
    assign grantValid = grantFound && !rAckSync && syncReady && (oDone == '0);

`ifdef HS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] rTimeoutCnt;

    assign timeoutHit = (state == ASSERT_RDY) && !rAckSync &&
                        (rTimeoutCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Cycles spent in ASSERT_RDY; abortedQ suppresses the second oDone.
    always_ff @(posedge iTxClk or negedge iRstnTx) begin
        if (!iRstnTx) begin
            rTimeoutCnt <= '0;
            abortedQ    <= 1'b0;
        end else begin
            if ((state == ASSERT_RDY) && (nextState == ASSERT_RDY)) begin
                rTimeoutCnt <= rTimeoutCnt + CNT_W'(1);
            end else begin
                rTimeoutCnt <= '0;
            end
            if (timeoutHit) begin
                abortedQ <= 1'b1;
            end else if (state == IDLE) begin
                abortedQ <= 1'b0;
            end
        end
    end
`else
    logic unusedTimeoutCfg;

    // The limit only matters when the abort path is built.
    assign unusedTimeoutCfg = ^TIMEOUT_CYCLES;
    assign timeoutHit       = 1'b0;
    assign abortedQ         = 1'b0;
`endif

    // State register.
    always_ff @(posedge iTxClk or negedge iRstnTx) begin
        if (!iRstnTx) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (grantValid) nextState = ASSERT_RDY;
            end
            ASSERT_RDY: begin
                if (rAckSync || timeoutHit) nextState = WAIT_ACK_LOW;
            end
            WAIT_ACK_LOW: begin
                if (!rAckSync) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Next values of the registered outputs and arbitration state.
    always_comb begin
        nxtTxRdy   = oTxRdy;
        nxtData    = oData;
        nxtDone    = '0;
        nxtTimeout = 1'b0;
        nxtPtr     = rPtr;
        nxtGrant   = rGrant;
        unique case (state)
            IDLE: begin
                if (grantValid) begin
                    nxtTxRdy = 1'b1;
                    nxtData  = iReqData[32'(grantIdx)*DATA_WIDTH +: DATA_WIDTH];
                    nxtGrant = grantIdx;
                    nxtPtr   = (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + PTR_W'(1);
                end
            end
            ASSERT_RDY: begin
                if (rAckSync) begin
                    nxtTxRdy = 1'b0;
                end else if (timeoutHit) begin
                    nxtTxRdy        = 1'b0;
                    nxtDone[rGrant] = 1'b1;
                    nxtTimeout      = 1'b1;
                end
            end
            WAIT_ACK_LOW: begin
                if (!rAckSync && !abortedQ) nxtDone[rGrant] = 1'b1;
            end
            default: begin
                nxtTxRdy = 1'b0;
            end
        endcase
    end

    // Output and arbitration registers.
    always_ff @(posedge iTxClk or negedge iRstnTx) begin
        if (!iRstnTx) begin
            oTxRdy   <= 1'b0;
            oData    <= '0;
            oDone    <= '0;
            oTimeout <= 1'b0;
            oBusy    <= 1'b0;
            rPtr     <= '0;
            rGrant   <= '0;
        end else begin
            oTxRdy   <= nxtTxRdy;
            oData    <= nxtData;
            oDone    <= nxtDone;
            oTimeout <= nxtTimeout;
            oBusy    <= (nextState != IDLE);
            rPtr     <= nxtPtr;
            rGrant   <= nxtGrant;
        end
    end

endmodule

// File: tb/tb_hs_tx_arbiter.sv
// tb_hs_tx_arbiter: scoreboard bench for hs_tx_arbiter (NUM_REQ=4, 32-bit
// payloads, TIMEOUT_CYCLES=15). Works with or without HS_ARB_TIMEOUT_EN.
module tb_hs_tx_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int TO = 15;

    typedef struct {
        logic [NR-1:0] done;
        logic [DW-1:0] data;
        logic          tmo;
    } exp_t;

    logic             iTxClk = 1'b0;
    logic             iRstnTx;
    logic [NR-1:0]    iReq;
    logic [NR*DW-1:0] iReqData;
    logic [NR-1:0]    oDone;
    logic             oBusy;
    logic             oTxRdy;
    logic [DW-1:0]    oData;
    logic             iRxAck;
    logic             oTimeout;

    exp_t          expQ[$];
    logic [DW-1:0] dataQ[NR][$];
    int            checks   = 0;
    int            failures = 0;
    int            mPtr     = 0;
    bit            respEn   = 1'b0;
    bit            respHold = 1'b0;

    hs_tx_arbiter #(
        .DATA_WIDTH     (DW),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .iTxClk   (iTxClk),
        .iRstnTx  (iRstnTx),
        .iReq     (iReq),
        .iReqData (iReqData),
        .oDone    (oDone),
        .oBusy    (oBusy),
        .oTxRdy   (oTxRdy),
        .oData    (oData),
        .iRxAck   (iRxAck),
        .oTimeout (oTimeout)
    );

    always #5 iTxClk = ~iTxClk;

    // Receiver: ack 3 cycles after oTxRdy rises, release once oTxRdy falls.
    initial begin
        int hi = 0;
        forever begin
            @(posedge iTxClk);
            #2;
            if (!respEn) begin
                hi = 0;
            end else if (oTxRdy) begin
                hi++;
                if (hi >= 3) iRxAck = 1'b1;
            end else begin
                hi = 0;
                if (!respHold) iRxAck = 1'b0;
            end
        end
    end

    // Monitor: scoreboard compare on oDone, requester bookkeeping, pulse width
    // and done-to-next-request spacing.
    initial begin
        logic          prevRdy = 1'b0;
        logic [NR-1:0] prevDone = '0;
        int            sinceDone = 0;
        bit            gapArmed = 1'b0;
        exp_t          e;
        forever begin
            @(posedge iTxClk);
            #1;
            if (!iRstnTx) begin
                prevRdy  = 1'b0;
                prevDone = '0;
                gapArmed = 1'b0;
                continue;
            end
            sinceDone++;
            if (oTxRdy && !prevRdy && gapArmed) begin
                checks++;
                if (sinceDone !== 2) begin
                    failures++;
                    $display("FAIL done_to_rdy_gap: got %0d cycles required 2", sinceDone);
                end
                gapArmed = 1'b0;
            end
            if (prevDone != '0) begin
                checks++;
                if (oDone !== '0) begin
                    failures++;
                    $display("FAIL done_width: oDone=%b still high, required 0", oDone);
                end
            end
            if (oDone != '0 && prevDone == '0) begin
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: oDone=%b data=%h required no transfer", oDone, oData);
                end else begin
                    e = expQ.pop_front();
                    if (oDone !== e.done || oData !== e.data || oTimeout !== e.tmo) begin
                        failures++;
                        $display("FAIL scoreboard: got done=%b data=%h tmo=%b required done=%b data=%h tmo=%b",
                                 oDone, oData, oTimeout, e.done, e.data, e.tmo);
                    end
                end
                for (int g = 0; g < NR; g++) begin
                    if (oDone[g]) begin
                        if (dataQ[g].size() > 0) void'(dataQ[g].pop_front());
                        if (dataQ[g].size() > 0) iReqData[g*DW +: DW] = dataQ[g][0];
                        else iReq[g] = 1'b0;
                    end
                end
                sinceDone = 0;
                gapArmed  = (iReq != '0) && !oTimeout;
            end
            prevRdy  = oTxRdy;
            prevDone = oDone;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic load_req(input int g, input logic [DW-1:0] d);
        dataQ[g].push_back(d);
        if (!iReq[g]) begin
            iReqData[g*DW +: DW] = d;
            iReq[g] = 1'b1;
        end
    endtask

    // Round-robin reference: expected order of all queued payloads.
    task automatic run_model(input bit tmo);
        int   cnt[NR];
        int   used[NR];
        int   total = 0;
        exp_t e;
        for (int i = 0; i < NR; i++) begin
            cnt[i]  = dataQ[i].size();
            used[i] = 0;
            total  += cnt[i];
        end
        repeat (total) begin
            for (int j = 0; j < NR; j++) begin
                int g = (mPtr + j) % NR;
                if (cnt[g] > 0) begin
                    e.done = NR'(1) << g;
                    e.data = dataQ[g][used[g]];
                    e.tmo  = tmo;
                    expQ.push_back(e);
                    used[g]++;
                    cnt[g]--;
                    mPtr = (g + 1) % NR;
                    break;
                end
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((expQ.size() != 0 || oBusy) && n < budget) begin
            @(posedge iTxClk);
            #3;
            n++;
        end
        checks++;
        if (expQ.size() != 0 || oBusy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: pending=%0d busy=%b required pending=0 busy=0", expQ.size(), oBusy);
            expQ.delete();
        end
    endtask

    task automatic wait_rdy(input logic level, input int budget, output bit ok);
        int n = 0;
        while (oTxRdy !== level && n < budget) begin
            @(posedge iTxClk);
            #1;
            n++;
        end
        ok = (oTxRdy === level);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_rdy: oTxRdy=%b required %b within %0d cycles", oTxRdy, level, budget);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if (oTxRdy !== 1'b0 || oBusy !== 1'b0 || oDone !== '0 || oData !== '0 || oTimeout !== 1'b0) begin
            failures++;
            $display("FAIL %s: rdy=%b busy=%b done=%b data=%h tmo=%b required all zero",
                     tag, oTxRdy, oBusy, oDone, oData, oTimeout);
        end
    endtask

    // Counts cycles with oTxRdy high over a window; any grant is an error.
    task automatic check_no_grant(input int cycles, input string tag);
        int hiCnt = 0;
        repeat (cycles) begin
            @(posedge iTxClk);
            #1;
            if (oTxRdy) hiCnt++;
        end
        checks++;
        if (hiCnt !== 0) begin
            failures++;
            $display("FAIL %s: oTxRdy high %0d cycles required 0", tag, hiCnt);
        end
    endtask

    // Drop a held ack and expect the first grant exactly 3 edges later.
    task automatic release_ack_and_expect_grant(input string tag);
        logic [2:0] seen;
        @(posedge iTxClk);
        #2;
        iRxAck = 1'b0;
        respEn = 1'b1;
        respHold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge iTxClk);
            #1;
            seen[k] = oTxRdy;
        end
        checks++;
        if (seen !== 3'b100) begin
            failures++;
            $display("FAIL %s: oTxRdy over 3 cycles=%b required 100", tag, seen);
        end
    endtask

    task automatic test_reset();
        iRstnTx = 1'b0;
        iReq = '0;
        iReqData = '0;
        iRxAck = 1'b0;
        repeat (3) @(posedge iTxClk);
        #1;
        check_outputs_zero("reset_values");
        @(negedge iTxClk);
        iRstnTx = 1'b1;
        mPtr = 0;
        respEn = 1'b1;
        repeat (4) @(posedge iTxClk);
        #1;
        check_outputs_zero("idle_after_reset");
    endtask

    task automatic test_all_requesting();
        @(posedge iTxClk);
        #2;
        load_req(0, 32'h1000_0000);
        load_req(0, 32'h1000_0001);
        load_req(1, 32'h2111_1111);
        load_req(2, 32'h3222_2222);
        load_req(3, 32'h4333_3333);
        run_model(1'b0);
        wait_idle(400);
    endtask

    task automatic test_single();
        @(posedge iTxClk);
        #2;
        load_req(2, 32'hDEAD_BEEF);
        run_model(1'b0);
        wait_idle(100);
        checks++;
        if (oData !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_data: oData=%h required deadbeef", oData);
        end
    endtask

    task automatic test_wrap();
        @(posedge iTxClk);
        #2;
        load_req(0, 32'h0A0A_0A0A);
        load_req(3, 32'h3C3C_3C3C);
        run_model(1'b0);
        wait_idle(200);
    endtask

    task automatic test_payload_hold();
        bit ok;
        @(posedge iTxClk);
        #2;
        load_req(1, 32'h5555_AAAA);
        run_model(1'b0);
        wait_rdy(1'b1, 20, ok);
        @(posedge iTxClk);
        #2;
        iReqData[1*DW +: DW] = 32'h0BAD_F00D;
        iReq[1] = 1'b0;
        @(posedge iTxClk);
        #1;
        checks++;
        if (oData !== 32'h5555_AAAA) begin
            failures++;
            $display("FAIL payload_hold: oData=%h required 5555aaaa", oData);
        end
        wait_idle(100);
    endtask

    task automatic test_stale_ack();
        @(posedge iTxClk);
        #2;
        respEn = 1'b0;
        iRxAck = 1'b1;
        repeat (4) @(posedge iTxClk);
        #2;
        load_req(0, 32'h7777_0000);
        iReq[3] = 1'b1;
        check_no_grant(8, "stale_ack_block");
        #1;
        iReq[3] = 1'b0;
        run_model(1'b0);
        release_ack_and_expect_grant("stale_ack_release");
        wait_idle(100);
    endtask

    task automatic test_timeout();
        bit ok;
        int n = 0;
        @(posedge iTxClk);
        #2;
        respEn = 1'b0;
        iRxAck = 1'b0;
        load_req(1, 32'hC0DE_0001);
`ifdef HS_ARB_TIMEOUT_EN
        run_model(1'b1);
        wait_rdy(1'b1, 20, ok);
        while (oTxRdy && n < 100) begin
            @(posedge iTxClk);
            #1;
            n++;
        end
        checks++;
        if (n !== TO) begin
            failures++;
            $display("FAIL timeout_len: oTxRdy high %0d cycles required %0d", n, TO);
        end
        wait_idle(20);
        repeat (10) @(posedge iTxClk);
        respEn = 1'b1;
`else
        run_model(1'b0);
        wait_rdy(1'b1, 20, ok);
        repeat (40) begin
            @(posedge iTxClk);
            #1;
            if (!oTxRdy || oTimeout) n++;
        end
        checks++;
        if (n !== 0) begin
            failures++;
            $display("FAIL no_timeout: %0d cycles with rdy low or tmo high, required 0", n);
        end
        respEn = 1'b1;
        wait_idle(100);
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        @(posedge iTxClk);
        #2;
        respEn = 1'b1;
        respHold = 1'b1;
        load_req(2, 32'hFACE_0002);
        run_model(1'b0);
        wait_rdy(1'b1, 20, ok);
        wait_rdy(1'b0, 40, ok);
        @(posedge iTxClk);
        #3;
        respEn = 1'b0;
        iRstnTx = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        expQ.delete();
        mPtr = 0;
        repeat (2) @(posedge iTxClk);
        #2;
        iRstnTx = 1'b1;
        check_no_grant(10, "post_reset_stale_ack");
        #1;
        run_model(1'b0);
        release_ack_and_expect_grant("post_reset_release");
        wait_idle(100);
    endtask

    initial begin
        test_reset();
        test_all_requesting();
        test_single();
        test_wrap();
        test_payload_hold();
        test_stale_ack();
        test_timeout();
        test_reset_mid();
        repeat (5) @(posedge iTxClk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
